// File: rtl/fifod2mac_pkg.sv
// fifod2mac_pkg: shared state encoding and constants for the fifod -> mac transmit bridge.
// Revision: 1.0
`default_nettype none

package fifod2mac_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WAIT  = 3'd1,
    S_START = 3'd2,
    S_SEND  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam int unsigned C_MAX_LEN = 1472;
  localparam int unsigned C_HDR_LEN = 4;
  localparam logic [7:0]  C_HDR_B0  = 8'h55;
  localparam logic [7:0]  C_HDR_B1  = 8'hAA;

endpackage

`default_nettype wire

// File: rtl/fifod2mac.sv
// fifod2mac: streams one frame from the ADC data FIFO into the MAC UDP transmit port.
// Optional header prefix enabled by FIFOD2MAC_HDR_EN.  Revision: 1.0
`default_nettype none

module fifod2mac
  import fifod2mac_pkg::*;
#(
  parameter int unsigned MAX_LEN = C_MAX_LEN,
  parameter int unsigned HDR_LEN = C_HDR_LEN
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fs,
  output logic        fd,
  output logic        err,
  input  logic [11:0] tx_len,
  input  logic [7:0]  dev_info,
  input  logic [11:0] fifod_count,
  output logic        fifod_rxen,
  input  logic [7:0]  fifod_rxd,
  output logic        udp_tx_start,
  output logic [15:0] udp_tx_len,
  input  logic        udp_tx_prep,
  input  logic        udp_tx_req,
  output logic [7:0]  udp_txd,
  input  logic        udp_tx_done
);

`ifdef FIFOD2MAC_HDR_EN
  localparam logic c_hdr_en = 1'b1;
`else
  localparam logic c_hdr_en = 1'b0;
`endif
  localparam logic [15:0] c_hdr_len = 16'(HDR_LEN);
  localparam logic [15:0] c_hdr     = c_hdr_en ? c_hdr_len : 16'd0;

  state_t      r_state, w_next;
  logic [11:0] r_len;
  logic [7:0]  r_dev;
  logic [15:0] r_cnt;
  logic [15:0] r_ulen;
  logic        r_err;
  logic [7:0]  r_txd;
  logic        r_sel;

  logic        w_accept, w_bad, w_pull, w_has, w_hdr;
  logic        w_rd, w_over, w_early, w_ok_done;
  logic [7:0]  w_hbyte, w_fcnt;

  assign w_accept  = (r_state == S_IDLE) && fs;
  assign w_bad     = (tx_len == 12'd0) || (32'(tx_len) > MAX_LEN);
  assign w_pull    = (r_state == S_SEND) && udp_tx_req;
  assign w_has     = r_cnt < r_ulen;
  assign w_hdr     = c_hdr_en && (r_cnt < c_hdr_len);
  assign w_rd      = w_pull && w_has && !w_hdr;
  assign w_over    = w_pull && !w_has;
  assign w_early   = (r_state == S_SEND) && udp_tx_done && w_has;
  assign w_ok_done = (r_state == S_SEND) && udp_tx_done && !w_has;

  always_comb begin
    w_next       = r_state;
    fd           = 1'b0;
    udp_tx_start = 1'b0;
    case (r_state)
      S_IDLE:  if (fs) w_next = w_bad ? S_DONE : S_WAIT;
      S_WAIT:  if (fifod_count >= r_len) w_next = S_START;
      S_START: if (udp_tx_prep) begin
                 udp_tx_start = 1'b1;
                 w_next       = S_SEND;
               end
      S_SEND:  if (udp_tx_done) w_next = S_DONE;
      S_DONE:  begin
                 fd = 1'b1;
                 if (!fs) w_next = S_IDLE;
               end
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_hbyte = 8'h00;
    case (r_cnt)
      16'd0:   w_hbyte = C_HDR_B0;
      16'd1:   w_hbyte = C_HDR_B1;
      16'd2:   w_hbyte = r_dev;
      16'd3:   w_hbyte = w_fcnt;
      default: w_hbyte = 8'h00;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_len   <= 12'd0;
      r_dev   <= 8'h00;
      r_cnt   <= 16'd0;
      r_ulen  <= 16'd0;
      r_err   <= 1'b0;
      r_txd   <= 8'h00;
      r_sel   <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_len  <= tx_len;
        r_dev  <= dev_info;
        r_cnt  <= 16'd0;
        r_ulen <= {4'd0, tx_len} + c_hdr;
        r_err  <= w_bad;
      end else begin
        if (w_over || w_early) r_err <= 1'b1;
        if (w_pull && w_has) r_cnt <= r_cnt + 16'd1;
      end
      // Payload bytes bypass r_txd: the FIFO's own read latency lines them up.
      r_sel <= w_rd;
      r_txd <= (w_pull && w_has && w_hdr) ? w_hbyte : 8'h00;
    end
  end

`ifdef FIFOD2MAC_HDR_EN
  logic [7:0] r_fcnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fcnt <= 8'h00;
    end else if (w_ok_done && !r_err && !w_over) begin
      r_fcnt <= r_fcnt + 8'h01;
    end
  end

  assign w_fcnt = r_fcnt;
`else
  assign w_fcnt = 8'h00;
`endif

  assign err        = r_err;
  assign fifod_rxen = w_rd;
  assign udp_tx_len = r_ulen;
  assign udp_txd    = r_sel ? fifod_rxd : r_txd;

endmodule

`default_nettype wire

// File: tb/tb_fifod2mac.sv
// tb_fifod2mac: directed self-checking bench for fifod2mac (FIFO and MAC modelled by stimulus).
// Revision: 1.0
`default_nettype none
`timescale 1ns/1ps

module tb_fifod2mac;

`ifdef FIFOD2MAC_HDR_EN
  localparam int HL = 4;
`else
  localparam int HL = 0;
`endif

  logic        clk, rst_n, fs, fd, err;
  logic [11:0] tx_len, fifod_count;
  logic [7:0]  dev_info, fifod_rxd, udp_txd;
  logic        fifod_rxen, udp_tx_start, udp_tx_prep, udp_tx_req, udp_tx_done;
  logic [15:0] udp_tx_len;

  logic [7:0]  q[$];
  int          n_chk = 0, n_fail = 0, n_rd = 0, n_start = 0, cyc;
  logic [7:0]  exp_fc = 8'h00;

  fifod2mac dut (
    .clk(clk), .rst_n(rst_n), .fs(fs), .fd(fd), .err(err),
    .tx_len(tx_len), .dev_info(dev_info), .fifod_count(fifod_count),
    .fifod_rxen(fifod_rxen), .fifod_rxd(fifod_rxd),
    .udp_tx_start(udp_tx_start), .udp_tx_len(udp_tx_len),
    .udp_tx_prep(udp_tx_prep), .udp_tx_req(udp_tx_req),
    .udp_txd(udp_txd), .udp_tx_done(udp_tx_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // FIFO with 1-cycle read latency, plus event monitors.
  always @(posedge clk) begin
    if (fifod_rxen) begin
      n_rd <= n_rd + 1;
      if (q.size() > 0) begin
        fifod_rxd   <= q.pop_front();
        fifod_count <= fifod_count - 12'd1;
      end
    end
    if (udp_tx_start) n_start <= n_start + 1;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int n, input logic [7:0] base);
    q.delete();
    for (int i = 0; i < n; i++) q.push_back(8'(base + 8'(i)));
    fifod_count = 12'(q.size());
  endtask

  function automatic logic [7:0] exp_byte(input int k, input int len, input logic [7:0] base);
    if (k < HL) begin
      case (k)
        0:       return 8'h55;
        1:       return 8'hAA;
        2:       return 8'h2A;
        default: return exp_fc;
      endcase
    end else if (k < HL + len) begin
      return 8'(base + 8'(k - HL));
    end
    return 8'h00;
  endfunction

  task automatic wait_start(output int c);
    c = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (udp_tx_start) begin
        c = i;
        break;
      end
    end
    chk("start_seen", {31'd0, c >= 0}, 32'd1);
    step();
  endtask

  task automatic begin_frame(input logic [11:0] len);
    int c;
    tx_len   = len;
    dev_info = 8'h2A;
    fs       = 1'b1;
    wait_start(c);
  endtask

  task automatic pull(input int n, input int len, input logic [7:0] base);
    for (int k = 0; k <= n; k++) begin
      udp_tx_req = (k < n);
      @(negedge clk);
      if (k > 0) chk($sformatf("txd%0d", k - 1), {24'd0, udp_txd}, {24'd0, exp_byte(k - 1, len, base)});
      step();
    end
  endtask

  task automatic done_pulse();
    udp_tx_done = 1'b1;
    step();
    udp_tx_done = 1'b0;
    @(negedge clk);
  endtask

  task automatic close_frame();
    step();
    fs = 1'b0;
    step();
    step();
    @(negedge clk);
    chk("idle_fd", {31'd0, fd}, 32'd0);
    step();
  endtask

  initial begin
    rst_n = 1'b0; fs = 1'b0; tx_len = '0; dev_info = '0; fifod_count = '0;
    fifod_rxd = '0; udp_tx_prep = 1'b0; udp_tx_req = 1'b0; udp_tx_done = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_fd", {31'd0, fd}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_rxen", {31'd0, fifod_rxen}, 32'd0);
    chk("rst_start", {31'd0, udp_tx_start}, 32'd0);
    chk("rst_len", {16'd0, udp_tx_len}, 32'd0);
    chk("rst_txd", {24'd0, udp_txd}, 32'd0);
    rst_n = 1'b1;
    udp_tx_prep = 1'b1;
    step();

    // Normal 8-byte frame.
    load(8, 8'h01); n_rd = 0; n_start = 0;
    begin_frame(12'd8);
    chk("n_txlen", {16'd0, udp_tx_len}, 32'(8 + HL));
    pull(HL + 8, 8, 8'h01);
    done_pulse();
    chk("n_fd", {31'd0, fd}, 32'd1);
    chk("n_err", {31'd0, err}, 32'd0);
    chk("n_rd", n_rd, 32'd8);
    chk("n_start", n_start, 32'd1);
    exp_fc = exp_fc + 8'h01;
    close_frame();

    // Wait for data: FIFO reports 10 of 16.
    load(16, 8'h10); fifod_count = 12'd10; n_start = 0;
    tx_len = 12'd16; dev_info = 8'h2A; fs = 1'b1;
    repeat (20) step();
    chk("wait_nostart", n_start, 32'd0);
    fifod_count = 12'd16;
    wait_start(cyc);
    chk("wait_lat", {31'd0, (cyc >= 1) && (cyc <= 2)}, 32'd1);
    pull(HL + 16, 16, 8'h10);
    done_pulse();
    chk("w_fd", {31'd0, fd}, 32'd1);
    chk("w_err", {31'd0, err}, 32'd0);
    exp_fc = exp_fc + 8'h01;
    close_frame();

    // Illegal lengths.
    for (int j = 0; j < 2; j++) begin
      n_rd = 0; n_start = 0;
      tx_len = (j == 0) ? 12'd0 : 12'd1473;
      fs = 1'b1;
      step(); step();
      @(negedge clk);
      chk($sformatf("bad%0d_err", j), {31'd0, err}, 32'd1);
      chk($sformatf("bad%0d_fd", j), {31'd0, fd}, 32'd1);
      chk($sformatf("bad%0d_rd", j), n_rd, 32'd0);
      chk($sformatf("bad%0d_start", j), n_start, 32'd0);
      close_frame();
    end

    // Early done after 3 payload bytes.
    load(8, 8'h01); n_rd = 0;
    begin_frame(12'd8);
    chk("err_clear", {31'd0, err}, 32'd0);
    pull(HL + 3, 8, 8'h01);
    done_pulse();
    chk("early_err", {31'd0, err}, 32'd1);
    chk("early_fd", {31'd0, fd}, 32'd1);
    udp_tx_req = 1'b1;
    repeat (3) step();
    @(negedge clk);
    chk("early_rd", n_rd, 32'd3);
    chk("early_txd", {24'd0, udp_txd}, 32'd0);
    udp_tx_req = 1'b0;
    close_frame();

    // Over-pull: 9th request on an 8-byte frame.
    load(8, 8'h01); n_rd = 0;
    begin_frame(12'd8);
    pull(HL + 9, 8, 8'h01);
    chk("over_err", {31'd0, err}, 32'd1);
    chk("over_rd", n_rd, 32'd8);
    done_pulse();
    chk("over_fd", {31'd0, fd}, 32'd1);
    close_frame();

    // Reset in the middle of SEND.
    load(8, 8'h01);
    begin_frame(12'd8);
    udp_tx_req = 1'b1;
    repeat (HL + 4) step();
    rst_n = 1'b0;
    #1;
    chk("mrst_fd", {31'd0, fd}, 32'd0);
    chk("mrst_err", {31'd0, err}, 32'd0);
    chk("mrst_rxen", {31'd0, fifod_rxen}, 32'd0);
    chk("mrst_start", {31'd0, udp_tx_start}, 32'd0);
    chk("mrst_len", {16'd0, udp_tx_len}, 32'd0);
    chk("mrst_txd", {24'd0, udp_txd}, 32'd0);
    udp_tx_req = 1'b0; fs = 1'b0;
    step();
    rst_n = 1'b1;
    exp_fc = 8'h00;
    step();
    load(8, 8'h21); n_rd = 0;
    begin_frame(12'd8);
    pull(HL + 8, 8, 8'h21);
    done_pulse();
    chk("post_fd", {31'd0, fd}, 32'd1);
    chk("post_err", {31'd0, err}, 32'd0);
    chk("post_rd", n_rd, 32'd8);
    exp_fc = exp_fc + 8'h01;
    close_frame();

`ifdef FIFOD2MAC_HDR_EN
    // Header frames until the frame counter wraps past 0xFF.
    for (int f = 0; f < 257; f++) begin
      load(2, 8'hD0);
      begin_frame(12'd2);
      chk("hdr_len", {16'd0, udp_tx_len}, 32'd6);
      pull(6, 2, 8'hD0);
      done_pulse();
      exp_fc = exp_fc + 8'h01;
      close_frame();
    end
    chk("hdr_fc_wrapped", {24'd0, exp_fc}, 32'h02);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/fifod2mac.md
# fifod2mac

Transmit-side bridge from the ADC data FIFO (fifod) to the UDP transmit interface of `mac`. It is the counterpart of `mac2fifoc`, which moves received UDP payload into the command FIFO. On a start flag from `cs`, the block:
- waits until the FIFO holds a full frame;
- requests a UDP transmission of the programmed length;
- streams bytes out of the FIFO as the MAC pulls them;
- reports done back to `cs`.

## Interface
Parameters:
- `MAX_LEN`, 1472: largest legal payload in bytes (one UDP datagram, no IP fragmentation).
- `HDR_LEN`, 4: header byte count, used only when `FIFOD2MAC_HDR_EN` is defined.

Ports:
- `clk` in 1: single clock for the block (the `gmii_txc` domain).
- `rst_n` in 1: asynchronous, active-low reset.
- `fs` in 1: start request from `cs`, level-sensitive, sampled only in IDLE.
- `fd` out 1: done, held high in DONE until `fs` is low.
- `err` out 1: sticky error, cleared on the next accepted `fs`.
- `tx_len` in 12: payload bytes taken from the FIFO, sampled when `fs` is accepted.
- `dev_info` in 8: header byte 2, sampled when `fs` is accepted.
- `fifod_count` in 12: FIFO read-side data count.
- `fifod_rxen` out 1: FIFO read enable (standard FIFO, 1-cycle read latency).
- `fifod_rxd` in 8: FIFO read data.
- `udp_tx_start` out 1: one-cycle request to the MAC to begin a datagram.
- `udp_tx_len` out 16: total UDP payload length, stable from START until DONE.
- `udp_tx_prep` in 1: MAC idle and able to accept `udp_tx_start`.
- `udp_tx_req` in 1: MAC pulls one byte.
- `udp_txd` out 8: data byte for the MAC.
- `udp_tx_done` in 1: one-cycle pulse, MAC finished the frame.

## Operation
States:
- **IDLE**: waiting for a start.
  - `fs`=1 latches `tx_len` and `dev_info`, clears `err` and the byte counter.
  - If `tx_len`==0 or `tx_len`>`MAX_LEN`: set `err`, go to DONE.
  - Otherwise go to WAIT.
- **WAIT**: waiting for data.
  - Go to START when `fifod_count` ≥ latched `tx_len`.
  - There is no timeout; `cs` owns recovery through reset.
- **START**: requesting the frame.
  - When `udp_tx_prep`=1, drive `udp_tx_start`=1 for exactly one cycle, then go to SEND.
- **SEND**: streaming bytes.
  - Each `udp_tx_req` cycle consumes one byte and increments the 16-bit byte counter.
  - While the counter is below `udp_tx_len`:
    - header bytes, when the header is enabled, come from registers;
    - payload bytes come from the FIFO, with `fifod_rxen` = `udp_tx_req`, combinational and in the same cycle.
  - `udp_tx_req` with counter = `udp_tx_len` is an over-pull: no FIFO read, `udp_txd`=0, set `err`.
  - `udp_tx_done` with counter = `udp_tx_len`: go to DONE.
  - `udp_tx_done` with counter below `udp_tx_len`: set `err`, go to DONE, perform no further reads.
- **DONE**: `fd`=1; go to IDLE when `fs`=0.

Arithmetic and data rules:
- `udp_tx_len` = `tx_len` zero-extended to 16 bits, plus `HDR_LEN` when the header is enabled.
- `fifod_rxen` is never asserted outside SEND, so at most `tx_len` FIFO reads occur per frame.
- `udp_txd` is 0 whenever no byte is due.

## Timing
- Reset values: `fd`=0, `err`=0, `fifod_rxen`=0, `udp_tx_start`=0, `udp_tx_len`=0, `udp_txd`=0, state IDLE, counters 0.
- Data latency: `udp_tx_req` at cycle t gives a valid `udp_txd` at t+1.
  - Header bytes are registered outputs.
  - Payload bytes are `fifod_rxd` selected through a registered mux select.
- Back-to-back `udp_tx_req` cycles stream one byte per cycle with no bubbles.
- Control latencies:
  - `fs` to leaving IDLE: 1 cycle.
  - WAIT condition met to START: 1 cycle.
  - `udp_tx_done` to `fd`=1: 1 cycle.
- Deasserting `fs` in WAIT, START or SEND has no effect.
- Reset mid-frame returns the block to IDLE asynchronously; FIFO contents are untouched (the FIFO is flushed by the separate `rst_fifod`).

## Configuration
- `FIFOD2MAC_HDR_EN` defined: each datagram is prefixed with `HDR_LEN`=4 bytes:
  - byte 0: 0x55;
  - byte 1: 0xAA;
  - byte 2: latched `dev_info`;
  - byte 3: 8-bit frame counter, incremented at each DONE without `err`, wrapping 0xFF→0x00, reset to 0.
- `FIFOD2MAC_HDR_EN` undefined: no header, `udp_tx_len`=`tx_len`, and the frame counter logic is absent.

## Structure
- Shared package `fifod2mac_pkg`:
  - state enum (IDLE, WAIT, START, SEND, DONE);
  - `MAX_LEN`;
  - header constants 0x55 and 0xAA;
  - `HDR_LEN`.
- The design is a single module; no sub-module is warranted.

## Test plan
- Normal frame: `tx_len`=8, FIFO preloaded with 0x01..0x08, MAC pulls 8 contiguous bytes.
  - Expect `udp_txd`=01..08 on t+1..t+8, exactly 8 `fifod_rxen` pulses, then `fd`=1 and `err`=0.
- Wait for data: `tx_len`=16 with `fifod_count`=10.
  - Expect the block to stay in WAIT and `udp_tx_start` never to pulse.
  - After `fifod_count` rises to 16, expect `udp_tx_start` 2 cycles later, once `udp_tx_prep` is 1.
- Illegal lengths: `tx_len`=0 and `tx_len`=1473.
  - Expect `err`=1, `fd`=1 within 2 cycles, and no `fifod_rxen` or `udp_tx_start`.
- Early done / over-pull:
  - `udp_tx_done` after 3 of 8 bytes: expect `err`=1 and no further reads.
  - 9th `udp_tx_req`: expect `udp_txd`=0 and `err`=1.
- Header (`FIFOD2MAC_HDR_EN`): `dev_info`=0x2A, `tx_len`=2.
  - Expect `udp_tx_len`=6 and stream 55 AA 2A 00 d0 d1.
  - Expect the counter to advance to 01 on the next frame and, after 256 frames, to wrap 0xFF→0x00.
- Reset mid-SEND: `rst_n` low after 4 bytes.
  - Expect all outputs to reach their reset values immediately.
  - Then expect a fresh `fs` to complete a full frame correctly.
